// File: rtl/flush_ctrl_if.sv
// rtl/flush_ctrl_if.sv - redirect request / flush broadcast bundle for flush_ctrl
interface flush_ctrl_if;
  logic        bp_req;
  logic [31:0] bp_addr;
  logic        rob_req;
  logic [31:0] rob_addr;
  logic        flush_out;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        stall;

  modport master (
    output bp_req, bp_addr, rob_req, rob_addr,
    input  flush_out, redirect_valid, redirect_addr, stall
  );

  modport slave (
    input  bp_req, bp_addr, rob_req, rob_addr,
    output flush_out, redirect_valid, redirect_addr, stall
  );
endinterface

// File: rtl/flush_ctrl.sv
// rtl/flush_ctrl.sv - arbitrates predictor/ROB redirects into one flush pulse plus drain stall
// Optional macro FLUSH_CTRL_STATS_EN adds saturating flush/drop statistics outputs.
module flush_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int ROB_FIRST    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  flush_ctrl_if.slave   bus
`ifdef FLUSH_CTRL_STATS_EN
  ,
  output logic [15:0]   bp_flush_cnt,
  output logic [15:0]   rob_flush_cnt,
  output logic [15:0]   drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  // DRAIN exits when the counter reads zero, so load one less than the length.
  localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic        any_req;
  logic        pick_rob;
  logic        accept;

  assign any_req  = bus.bp_req | bus.rob_req;
  assign pick_rob = bus.rob_req & (~bus.bp_req | (ROB_FIRST != 0));
  assign accept   = rdy & (state == IDLE) & any_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = FLUSH;
      FLUSH:   state_nx = (DRAIN_CYCLES > 0) ? DRAIN : IDLE;
      DRAIN:   if (cnt == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.flush_out      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    case (state)
      FLUSH: begin
        bus.flush_out      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.stall          = 1'b1;
      end
      DRAIN:   bus.stall = 1'b1;
      default: ;
    endcase
  end

  assign bus.redirect_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 4'd0;
      addr_q <= 32'd0;
    end else if (rdy) begin
      if (accept) begin
        addr_q <= pick_rob ? bus.rob_addr : bus.bp_addr;
      end
      if (state == FLUSH) begin
        cnt <= DRAIN_LOAD;
      end else if ((state == DRAIN) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef FLUSH_CTRL_STATS_EN
  logic        bp_drop;
  logic        rob_drop;
  logic [16:0] drop_sum;

  // A losing simultaneous request is discarded just like a stale one.
  assign bp_drop  = bus.bp_req  & ((state != IDLE) | (bus.rob_req & (ROB_FIRST != 0)));
  assign rob_drop = bus.rob_req & ((state != IDLE) | (bus.bp_req  & (ROB_FIRST == 0)));
  assign drop_sum = {1'b0, drop_cnt} + {16'd0, bp_drop} + {16'd0, rob_drop};

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_flush_cnt  <= 16'd0;
      rob_flush_cnt <= 16'd0;
      drop_cnt      <= 16'd0;
    end else if (rdy) begin
      if (accept && !pick_rob && (bp_flush_cnt != 16'hFFFF)) begin
        bp_flush_cnt <= bp_flush_cnt + 16'd1;
      end
      if (accept && pick_rob && (rob_flush_cnt != 16'hFFFF)) begin
        rob_flush_cnt <= rob_flush_cnt + 16'd1;
      end
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule
